// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, LSB first. An internal divider produces
//                OVERSAMPLE ticks per bit; the start bit is qualified at its
//                middle, data and stop bits are sampled one bit period apart.
//                Received bytes are presented on a valid/ready holding
//                register. Framing errors and overruns are flagged with
//                one-cycle pulses.
//
//  Ports       : clk        system clock, all logic on rising edge
//                rst        synchronous active-high reset
//                rx         asynchronous serial input, idle high
//                rx_data    received byte, valid while rx_valid = 1
//                rx_valid   holding register full
//                rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//                frame_err  one-cycle pulse: stop bit sampled low
//                overrun    one-cycle pulse: byte completed while full
//                rx_busy    receiver is in any state other than idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // OVERSAMPLE is expected to be even and at least 4 so that the half-bit
    // point of the start bit is a whole number of ticks.
    localparam int c_DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_TCNT_W   = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [c_TCNT_W-1:0] c_HALF_LAST = c_TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TCNT_W-1:0] c_FULL_LAST = c_TCNT_W'(OVERSAMPLE - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = c_TCNT_W'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    // ------------------------------------------------------------------------
    // Oversampling tick divider: free-running 0..DIV-1, tick on wrap.
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_os_tick;

    assign w_os_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_os_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Input synchronizer (two flops, reset to idle level).
    //
    // r_fill marks when r_sync2 carries a real line sample rather than its
    // reset value. r_rxs_hi records that the synchronized line was genuinely
    // high on the previous cycle, so a frame only starts on a true falling
    // edge. Without this, a reset taken while the line is low mid-frame
    // would be followed by a bogus frame built from the tail of the old one.
    // ------------------------------------------------------------------------
    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_fill;
    logic       r_rxs_hi;
    logic       w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_fill   <= 2'b00;
            r_rxs_hi <= 1'b0;
        end else begin
            r_sync1  <= rx;
            r_sync2  <= r_sync1;
            r_fill   <= {r_fill[0], 1'b1};
            r_rxs_hi <= r_fill[1] & r_sync2;
        end
    end

    assign w_fall = r_rxs_hi & ~r_sync2;

    // ------------------------------------------------------------------------
    // Receive FSM and holding register
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_tcnt      <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer handshake. A byte load later in this block overrides
            // the clear, which gives load-and-accept in the same cycle.
            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= c_ST_START;
                        r_tcnt  <= '0;
                    end
                end

                c_ST_START: begin
                    if (w_os_tick) begin
                        if (r_tcnt == c_HALF_LAST) begin
                            // Middle of the start bit: still low means a real
                            // frame, high means a glitch that is dropped.
                            r_tcnt <= '0;
                            if (!r_sync2) begin
                                r_state   <= c_ST_DATA;
                                r_bit_idx <= 3'd0;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_TCNT_ONE;
                        end
                    end
                end

                c_ST_DATA: begin
                    if (w_os_tick) begin
                        if (r_tcnt == c_FULL_LAST) begin
                            r_tcnt             <= '0;
                            r_shift[r_bit_idx] <= r_sync2;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= c_ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_TCNT_ONE;
                        end
                    end
                end

                c_ST_STOP: begin
                    if (w_os_tick) begin
                        if (r_tcnt == c_FULL_LAST) begin
                            r_tcnt <= '0;
                            if (r_sync2) begin
                                // Return to idle at mid stop bit so that a
                                // start bit following with no gap is caught.
                                r_state <= c_ST_IDLE;
                                if (!r_valid || rx_ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= c_ST_BREAK;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + c_TCNT_ONE;
                        end
                    end
                end

                c_ST_BREAK: begin
                    // Hold here while the line stays low so a stuck-low line
                    // cannot produce a stream of frames.
                    if (r_sync2) begin
                        r_state <= c_ST_IDLE;
                        r_tcnt  <= '0;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_tcnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Stimulus pushes expected
//                bytes into a queue; a monitor pops and compares each time
//                the receiver presents a new byte. Directed frames cover a
//                single byte, back-to-back frames, glitch rejection, framing
//                error, overrun, load-with-accept and reset mid-frame.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CLK_FREQ = 1_600_000;
    localparam int c_BAUD     = 10_000;
    localparam int c_OS       = 16;
    localparam int c_BIT      = 160;   // clocks per bit (DIV = 10)

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ   (c_CLK_FREQ),
        .BAUD       (c_BAUD),
        .OVERSAMPLE (c_OS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;     // index of the most recent rising edge
    logic [7:0] exp_q[$];
    int         n_events = 0;
    int         ev_cyc   = 0;
    int         n_ferr   = 0;     // cycles with frame_err high
    int         n_ovr    = 0;     // cycles with overrun high
    int         ovr_cyc  = 0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples 1 ns after each rising edge. A new byte is presented
    // when rx_valid rises, or stays high across an edge at which the old
    // byte was accepted (load and accept together).
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        logic [7:0] exp_b;
        #1;
        if (rx_valid && (!prev_valid || rx_ready_at_edge)) begin
            n_events++;
            ev_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte actual=0x%02h required=none",
                         rx_data);
            end else begin
                exp_b = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_b});
            end
        end
        if (frame_err) n_ferr++;
        if (overrun) begin
            n_ovr++;
            ovr_cyc = cyc;
        end
        prev_valid = rx_valid;
    end

    // rx_ready only changes on falling edges, so its value 1 ns after a
    // rising edge is the value that edge sampled.
    logic rx_ready_at_edge;
    assign rx_ready_at_edge = rx_ready;

    // ------------------------------------------------------------------------
    // Stimulus helpers (called on a falling edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (c_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic wait_events(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_events < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_events < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, n_events, n);
        end
    endtask

    task automatic accept_pulse();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic align10();
        while (cyc % 10 != 0) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int s0, lat, s1, s2, delta, target, guard, ev_before;

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset_rx_data",   {24'd0, rx_data}, 32'h00);
        check("reset_rx_valid",  {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun",   {31'd0, overrun}, 32'd0);
        check("reset_rx_busy",   {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single byte, consumer not ready
        exp_q.push_back(8'hA5);
        s0 = cyc;
        send(8'hA5, 1'b1);
        wait_events(1, 400, "single");
        lat = ev_cyc - s0;
        check($sformatf("single_latency_%0d_in_window", lat),
              {31'd0, (lat >= 1443 && lat <= 1763)}, 32'd1);
        repeat (50) @(negedge clk);
        check("single_valid_held", {31'd0, rx_valid}, 32'd1);
        check("single_data_held",  {24'd0, rx_data}, 32'hA5);
        accept_pulse();
        check("single_valid_cleared", {31'd0, rx_valid}, 32'd0);
        check("single_data_kept",     {24'd0, rx_data}, 32'hA5);
        repeat (20) @(negedge clk);

        // Back-to-back frames, consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        wait_events(4, 400, "b2b");
        repeat (20) @(negedge clk);
        rx_ready = 1'b0;
        check("b2b_events",    n_events, 32'd4);
        check("b2b_frame_err", n_ferr, 32'd0);
        check("b2b_overrun",   n_ovr, 32'd0);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_busy_during", {31'd0, rx_busy}, 32'd1);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy_after", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_byte",    n_events, 32'd4);

        // Framing error: stop bit low, line held low afterwards
        send(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_pulses",     n_ferr, 32'd1);
        check("ferr_busy_low",   {31'd0, rx_busy}, 32'd1);
        check("ferr_valid",      {31'd0, rx_valid}, 32'd0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_busy_after", {31'd0, rx_busy}, 32'd0);
        check("ferr_no_byte",    n_events, 32'd4);
        repeat (40) @(negedge clk);

        // Overrun: second byte dropped while first is held
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        repeat (40) @(negedge clk);
        align10();
        s1 = cyc;
        send(8'h22, 1'b1);
        repeat (40) @(negedge clk);
        check("ovr_pulses",   n_ovr, 32'd1);
        check("ovr_data",     {24'd0, rx_data}, 32'h11);
        check("ovr_valid",    {31'd0, rx_valid}, 32'd1);
        delta = ovr_cyc - s1;
        accept_pulse();
        repeat (20) @(negedge clk);

        // Same again, with rx_ready high exactly at the load edge, which
        // sits at the same offset from the start edge as the overrun did.
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        repeat (40) @(negedge clk);
        exp_q.push_back(8'h22);
        align10();
        s2     = cyc;
        target = s2 + delta;
        fork
            send(8'h22, 1'b1);
            begin
                guard = 0;
                while (cyc < target - 1 && guard < 4000) begin
                    @(negedge clk);
                    guard++;
                end
                accept_pulse();
            end
        join
        repeat (40) @(negedge clk);
        check("lda_overrun", n_ovr, 32'd1);
        check("lda_data",    {24'd0, rx_data}, 32'h22);
        check("lda_valid",   {31'd0, rx_valid}, 32'd1);
        check("lda_events",  n_events, 32'd7);

        // Reset during bit 3 of 0x81, then a clean frame
        ev_before = n_events;
        fork
            send(8'h81, 1'b1);
            begin
                repeat (c_BIT * 4 + 80) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_rx_data",   {24'd0, rx_data}, 32'h00);
                check("rst_rx_valid",  {31'd0, rx_valid}, 32'd0);
                check("rst_rx_busy",   {31'd0, rx_busy}, 32'd0);
                check("rst_frame_err", {31'd0, frame_err}, 32'd0);
                check("rst_overrun",   {31'd0, overrun}, 32'd0);
            end
        join
        repeat (200) @(negedge clk);
        check("rst_no_byte",   n_events, ev_before);
        check("rst_no_flags",  n_ferr + n_ovr, 32'd2);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1);
        wait_events(ev_before + 1, 400, "post_rst");
        check("post_rst_data", {24'd0, rx_data}, 32'h7E);
        accept_pulse();
        repeat (20) @(negedge clk);

        check("queue_drained", exp_q.size(), 32'd0);
        check("final_frame_err", n_ferr, 32'd1);
        check("final_overrun",   n_ovr, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first. Recovers bytes from the asynchronous serial line using an internal oversampling tick divider.
- Presents each received byte on a valid/ready holding register.
- Flags framing errors and overruns.
- Sits between the board RX pin and the controller's command/FIFO logic. It is the receive-side counterpart to the transmit path's baud timing.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit. Must be even and ≥ 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  received byte, valid while rx_valid = 1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: byte completed while holding register still full.
- rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Tick divider
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division.
  - Counter width $clog2(DIV); it counts 0..DIV-1 and free-runs.
  - os_tick is high for one cycle when the count wraps.
  - Error from the integer truncation is accepted.
- Synchronizer
  - rx passes through 2 flops, both reset to 1. rxs = second flop.
  - Latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK. A tick counter tcnt is cleared on every state entry.
  - IDLE: rxs = 0 → START.
  - START: count os_tick. At tcnt reaching OVERSAMPLE/2 (mid start bit), sample rxs:
    - 0 → DATA (tcnt = 0, bit index = 0).
    - 1 → IDLE (glitch rejected, no flag).
  - DATA: each OVERSAMPLE ticks, sample rxs into shift[bit index]. LSB first, 8 bits. After bit 7 → STOP.
  - STOP: after OVERSAMPLE ticks (mid stop bit), sample rxs:
    - 1 → load byte, → IDLE. Back-to-back frames must be received with no gap.
    - 0 → frame_err pulse, byte discarded, → BREAK.
  - BREAK: wait for rxs = 1, then → IDLE. This prevents a held-low line from generating repeated frames.
- Holding register
  - On byte load with rx_valid = 0: rx_data ← byte, rx_valid ← 1 on the next cycle.
  - Accept: rx_valid & rx_ready → rx_valid ← 0 on the next cycle. rx_data holds its last value.
  - Load while rx_valid = 1 and no accept in the same cycle: new byte dropped, old rx_data kept, overrun pulses for 1 cycle.
  - Load and accept in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- Reset values: rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, rx_busy = 0. FSM → IDLE, counters = 0.
- Reset mid-frame aborts the frame with no flags raised. Reception resumes on the next falling edge after rst deasserts.
- rx_ready is ignored while rx_valid = 0.

Test Plan:
- Bench uses CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
- Single byte: send 0xA5 as 8N1, rx_ready=0 → rx_valid rises within 2 + 1 + 10×160 clk (±1 bit) of the start edge. rx_data = 0xA5, rx_valid stays high. Then pulse rx_ready for 1 cycle → rx_valid = 0 on the next cycle.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap, rx_ready tied 1 → three rx_valid events with data 0x00, 0xFF, 0x3C, no frame_err, no overrun.
- Glitch and framing:
  - rx low for 40 clk (< half bit) → no rx_valid, FSM returns to IDLE.
  - Send 0x55 with stop bit 0 → one frame_err pulse, rx_valid stays 0, rx_busy stays high until rx returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 → rx_data = 0x11, one overrun pulse at the 0x22 stop sample. Repeat with rx_ready asserted exactly in the load cycle → rx_data = 0x22, no overrun.
- Reset mid-frame: assert rst for 1 cycle during bit 3 of 0x81 → all outputs 0, no rx_valid for the aborted frame. Then send 0x7E → rx_data = 0x7E.
